mont_exp_ctrl: RTL and testbench
================================

Name: mont_exp_ctrl

Overview:
- Sequencer that computes modular exponentiation y = x^e mod m by issuing a chain of Montgomery multiplications to one external Montgomery multiplier instance.
- Uses MSB-first square-and-multiply.
- Sits between a host/top-level register block and the multiplier. It owns the multiplier's enable_p, a, b, m and m_size inputs, and consumes its y and done_irq_p outputs.
- Handles conversion into and out of the Montgomery domain using a host-supplied R^2 mod m.

Parameters:
- NBITS, 4096, operand, modulus and result width.
- PBITS, 8, multiplier digit width; passed through to the multiplier, not used internally.
- EBITS, NBITS, exponent register width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- start_p  in  1  one-cycle start pulse; ignored while busy.
- x  in  NBITS  base, with x < m.
- e  in  EBITS  exponent.
- e_bits  in  $clog2(EBITS)+1  number of exponent bits to scan; 0 means e is treated as 0.
- m  in  NBITS  odd modulus.
- m_size  in  $clog2(NBITS)+3  modulus size, passed through.
- r2_red  in  NBITS  R^2 mod m, with R = 2^m_size.
- busy  out  1  high from the cycle after an accepted start_p until done_p.
- result  out  NBITS  x^e mod m; valid when done_p is high, held until the next accepted start.
- done_p  out  1  one-cycle completion pulse.
- mm_enable_p  out  1  start pulse to the multiplier.
- mm_a  out  NBITS  multiplier operand a.
- mm_b  out  NBITS  multiplier operand b.
- mm_m  out  NBITS  modulus driven to the multiplier.
- mm_m_size  out  $clog2(NBITS)+3  m_size driven to the multiplier.
- mm_y  in  NBITS  multiplier result (a·b·R^-1 mod m).
- mm_done_p  in  1  multiplier done pulse; mm_y is valid in the same cycle.

Behaviour:
- Reset (rst_n low at posedge clk):
  - state=IDLE.
  - busy, done_p, mm_enable_p = 0.
  - result, mm_a, mm_b, mm_m, mm_m_size, acc, xm and bit index = 0.
  - Reset mid-operation aborts immediately; a later mm_done_p is ignored while in IDLE.
- On start_p in IDLE: latch x, e, e_bits, m, m_size and r2_red. Drive mm_m/mm_m_size from the latched copies for the whole run.
- States:
  - IDLE
  - CONV_X: xm = MM(x, r2)
  - CONV_1: acc = MM(1, r2) = R mod m
  - SQR: acc = MM(acc, acc)
  - MUL: acc = MM(acc, xm)
  - FROM_M: res = MM(acc, 1)
  - DONE
- Each MM state:
  - On entry, mm_a/mm_b are registered and mm_enable_p pulses high for exactly one cycle, the first cycle in the state.
  - Operands stay stable until mm_done_p.
  - On mm_done_p, mm_y is captured into the destination register and the state advances on the next edge.
  - Exactly one mm_enable_p is issued per MM state.
- Transitions:
  - IDLE -> CONV_X -> CONV_1.
  - CONV_1 -> SQR if e_bits>0, else FROM_M.
  - Bit index i starts at e_bits-1.
  - SQR -> MUL if e[i]=1.
  - SQR -> next SQR with i-1 if e[i]=0 and i>0.
  - SQR -> FROM_M if e[i]=0 and i=0.
  - MUL -> next SQR with i-1 if i>0, else FROM_M.
  - FROM_M -> DONE.
  - DONE: result=acc output, done_p=1 for one cycle, busy=0, then IDLE.
- busy falls in the same cycle done_p rises.
- start_p on the DONE cycle is ignored; start_p on the first IDLE cycle is accepted.
- Operation count = 3 + e_bits + popcount(e[e_bits-1:0]).
- mm_done_p arriving in a state with no outstanding request is ignored.
- e_bits > EBITS is saturated to EBITS.

Optional Feature:
- Macro MONT_EXP_CT_EN.
- Defined (constant-time): MUL is entered after every SQR regardless of e[i]. On e[i]=0 the product is computed but discarded, and acc is unchanged. Operation count = 3 + 2·e_bits, independent of e.
- Undefined: MUL is skipped for zero bits, as described in Behaviour.

Decomposition:
- Package mont_exp_pkg:
  - state enum type mont_exp_state_t with the 7 states.
  - localparam widths for m_size and e_bits derived from NBITS/EBITS.
  - constant MM_ONE = NBITS'(1).
- Sub-module mont_exp_bitscan:
  - holds latched e and index i.
  - provides cur_bit, last_bit and a step strobe.
  - keeps the FSM free of the shift/index logic.
- The multiplier itself stays external and is instantiated by the wrapper/bench.

Test Plan:
- NBITS=8, m=13, m_size=4, r2_red=9, x=2, e=5, e_bits=3, behavioural multiplier model -> result=6; 8 mm_enable_p pulses; done_p one cycle; busy high throughout.
- Same as above but e=0, e_bits=0 -> result=1; 3 multiplier ops (CONV_X, CONV_1, FROM_M).
- m=13, x=12, e=255, e_bits=8 -> result=12 (odd power of -1); 19 ops; with MONT_EXP_CT_EN: 19 ops and e=128 also 19 ops, result=1 (even power).
- Second start_p during busy, mid-SQR, with different x -> ignored; result equals the first job's value; op count unchanged.
- rst_n low for one cycle during MUL, followed by a stale mm_done_p -> all outputs 0, state IDLE, no capture; a new start with x=3, e=4 -> result=3 (81 mod 13).

Source files
------------

// File: rtl/mont_exp_pkg.sv
// Shared types and width helpers for the Montgomery modular-exponentiation sequencer.
package mont_exp_pkg;

    localparam int unsigned DEF_NBITS = 4096;
    localparam int unsigned DEF_PBITS = 8;

    // Width of the modulus-size field for a given operand width.
    function automatic int unsigned msize_w(input int unsigned nbits);
        return $clog2(nbits) + 3;
    endfunction

    // Width of the exponent bit-count field (must be able to hold EBITS itself).
    function automatic int unsigned ebits_w(input int unsigned ebits);
        return $clog2(ebits) + 1;
    endfunction

    // Width of the exponent bit index.
    function automatic int unsigned idx_w(input int unsigned ebits);
        return (ebits > 1) ? $clog2(ebits) : 1;
    endfunction

    localparam logic [DEF_NBITS-1:0] MM_ONE = DEF_NBITS'(1);

    typedef enum logic [2:0] {
        IDLE,
        CONV_X,
        CONV_1,
        SQR,
        MUL,
        FROM_M,
        DONE
    } mont_exp_state_t;

endpackage

// File: rtl/mont_exp_ctrl_if.sv
// Request/response bus between the exponentiation sequencer and the Montgomery multiplier.
interface mont_exp_ctrl_if import mont_exp_pkg::*; #(
    parameter int unsigned NBITS   = DEF_NBITS,
    parameter int unsigned MSIZE_W = msize_w(NBITS)
);
    logic               enable_p;
    logic [NBITS-1:0]   a;
    logic [NBITS-1:0]   b;
    logic [NBITS-1:0]   m;
    logic [MSIZE_W-1:0] m_size;
    logic [NBITS-1:0]   y;
    logic               done_p;

    modport master (
        output enable_p, a, b, m, m_size,
        input  y, done_p
    );

    modport slave (
        input  enable_p, a, b, m, m_size,
        output y, done_p
    );
endinterface

// File: rtl/mont_exp_bitscan.sv
// MSB-first exponent scanner: holds the latched exponent and the current bit index.
module mont_exp_bitscan import mont_exp_pkg::*; #(
    parameter  int unsigned EBITS = 8,
    localparam int unsigned EW    = ebits_w(EBITS),
    localparam int unsigned IW    = idx_w(EBITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [EBITS-1:0] e_in,
    input  logic [EW-1:0]    nbits,
    input  logic             step,
    output logic             cur_bit,
    output logic             last_bit,
    output logic             no_bits
);

    logic [EBITS-1:0] e_q;
    logic [IW-1:0]    idx_q;
    logic             last_q;
    logic             none_q;

    // nbits is already saturated to EBITS by the caller.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_q    <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
            none_q <= 1'b0;
        end else if (load) begin
            e_q    <= e_in;
            idx_q  <= (nbits == '0) ? '0 : IW'(nbits - EW'(1));
            last_q <= (nbits <= EW'(1));
            none_q <= (nbits == '0);
        end else if (step && (idx_q != '0)) begin
            idx_q  <= idx_q - IW'(1);
            last_q <= (idx_q == IW'(1));
        end
    end

    assign cur_bit  = e_q[idx_q];
    assign last_bit = last_q;
    assign no_bits  = none_q;

endmodule

// File: rtl/mont_exp_ctrl.sv
// Square-and-multiply sequencer for y = x^e mod m over an external Montgomery multiplier.
// Define MONT_EXP_CT_EN for constant-time operation (a multiply follows every square).
module mont_exp_ctrl import mont_exp_pkg::*; #(
    parameter  int unsigned NBITS   = DEF_NBITS,
    parameter  int unsigned PBITS   = DEF_PBITS,
    parameter  int unsigned EBITS   = NBITS,
    localparam int unsigned MSIZE_W = msize_w(NBITS),
    localparam int unsigned EW      = ebits_w(EBITS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_p,
    input  logic [NBITS-1:0]   x,
    input  logic [EBITS-1:0]   e,
    input  logic [EW-1:0]      e_bits,
    input  logic [NBITS-1:0]   m,
    input  logic [MSIZE_W-1:0] m_size,
    input  logic [NBITS-1:0]   r2_red,
    output logic               busy,
    output logic [NBITS-1:0]   result,
    output logic               done_p,
    mont_exp_ctrl_if.master    mm
);

    localparam logic [NBITS-1:0] ONE = NBITS'(MM_ONE);

    // The digit width only matters to the multiplier; reject nonsense configurations early.
    if (PBITS == 0 || PBITS > NBITS) begin : g_bad_pbits
        $error("mont_exp_ctrl: PBITS must be in 1..NBITS");
    end

    mont_exp_state_t    state_q, state_d;
    logic [NBITS-1:0]   acc_q, acc_d;
    logic [NBITS-1:0]   xm_q, xm_d;
    logic [NBITS-1:0]   r2_q, r2_d;
    logic [NBITS-1:0]   a_q, a_d;
    logic [NBITS-1:0]   b_q, b_d;
    logic [NBITS-1:0]   m_q, m_d;
    logic [MSIZE_W-1:0] msize_q, msize_d;
    logic               en_q, en_d;
    logic               pending_q, pending_d;
    logic               busy_d, done_d;
    logic [NBITS-1:0]   result_d;

    logic               load_c, step_c, issue_c, capture_c;
    logic [NBITS-1:0]   acc_new_c;
    logic [EW-1:0]      nbits_sat_c;
    logic               cur_bit, last_bit, no_bits;

    assign nbits_sat_c = (e_bits > EW'(EBITS)) ? EW'(EBITS) : e_bits;

    mont_exp_bitscan #(.EBITS(EBITS)) u_bitscan (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_c),
        .e_in     (e),
        .nbits    (nbits_sat_c),
        .step     (step_c),
        .cur_bit  (cur_bit),
        .last_bit (last_bit),
        .no_bits  (no_bits)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            xm_q      <= '0;
            r2_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            m_q       <= '0;
            msize_q   <= '0;
            en_q      <= 1'b0;
            pending_q <= 1'b0;
            busy      <= 1'b0;
            done_p    <= 1'b0;
            result    <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            xm_q      <= xm_d;
            r2_q      <= r2_d;
            a_q       <= a_d;
            b_q       <= b_d;
            m_q       <= m_d;
            msize_q   <= msize_d;
            en_q      <= en_d;
            pending_q <= pending_d;
            busy      <= busy_d;
            done_p    <= done_d;
            result    <= result_d;
        end
    end

    // Next operands are formed from mm.y directly so each new request issues on the capture edge.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        xm_d      = xm_q;
        r2_d      = r2_q;
        a_d       = a_q;
        b_d       = b_q;
        m_d       = m_q;
        msize_d   = msize_q;
        en_d      = 1'b0;
        pending_d = pending_q;
        busy_d    = busy;
        done_d    = 1'b0;
        result_d  = result;
        load_c    = 1'b0;
        step_c    = 1'b0;
        issue_c   = 1'b0;
        capture_c = pending_q & mm.done_p;
        acc_new_c = mm.y;

        if (capture_c) pending_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_p) begin
                    r2_d    = r2_red;
                    m_d     = m;
                    msize_d = m_size;
                    load_c  = 1'b1;
                    busy_d  = 1'b1;
                    a_d     = x;
                    b_d     = r2_red;
                    state_d = CONV_X;
                    issue_c = 1'b1;
                end
            end
            CONV_X: begin
                if (capture_c) begin
                    xm_d    = mm.y;
                    a_d     = ONE;
                    b_d     = r2_q;
                    state_d = CONV_1;
                    issue_c = 1'b1;
                end
            end
            CONV_1: begin
                if (capture_c) begin
                    acc_d   = mm.y;
                    a_d     = mm.y;
                    b_d     = no_bits ? ONE : mm.y;
                    state_d = no_bits ? FROM_M : SQR;
                    issue_c = 1'b1;
                end
            end
            SQR: begin
                if (capture_c) begin
                    acc_d   = mm.y;
                    a_d     = mm.y;
                    issue_c = 1'b1;
`ifdef MONT_EXP_CT_EN
                    b_d     = xm_q;
                    state_d = MUL;
`else
                    if (cur_bit) begin
                        b_d     = xm_q;
                        state_d = MUL;
                    end else if (!last_bit) begin
                        b_d     = mm.y;
                        step_c  = 1'b1;
                        state_d = SQR;
                    end else begin
                        b_d     = ONE;
                        state_d = FROM_M;
                    end
`endif
                end
            end
            MUL: begin
                if (capture_c) begin
`ifdef MONT_EXP_CT_EN
                    // Dummy multiply on a zero bit: product is discarded.
                    acc_new_c = cur_bit ? mm.y : acc_q;
`endif
                    acc_d   = acc_new_c;
                    a_d     = acc_new_c;
                    issue_c = 1'b1;
                    if (!last_bit) begin
                        b_d     = acc_new_c;
                        step_c  = 1'b1;
                        state_d = SQR;
                    end else begin
                        b_d     = ONE;
                        state_d = FROM_M;
                    end
                end
            end
            FROM_M: begin
                if (capture_c) begin
                    result_d = mm.y;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue_c) begin
            en_d      = 1'b1;
            pending_d = 1'b1;
        end
    end

    assign mm.enable_p = en_q;
    assign mm.a        = a_q;
    assign mm.b        = b_q;
    assign mm.m        = m_q;
    assign mm.m_size   = msize_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed bench for mont_exp_ctrl with a behavioural Montgomery multiplier (NBITS=8).
module tb_mont_exp_ctrl;

    localparam int unsigned NB  = 8;
    localparam int unsigned EB  = 8;
    localparam int unsigned EW  = 4;
    localparam int unsigned MW  = 6;
    localparam int          LAT = 3;
`ifdef MONT_EXP_CT_EN
    localparam bit CT_MODE = 1'b1;
`else
    localparam bit CT_MODE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_p = 1'b0;
    logic [NB-1:0] x = '0;
    logic [EB-1:0] e = '0;
    logic [EW-1:0] e_bits = '0;
    logic [NB-1:0] m = '0;
    logic [MW-1:0] m_size = '0;
    logic [NB-1:0] r2_red = '0;
    logic          busy;
    logic [NB-1:0] result;
    logic          done_p;

    always #5 clk = ~clk;

    mont_exp_ctrl_if #(.NBITS(NB)) mm_if ();

    mont_exp_ctrl #(.NBITS(NB), .PBITS(4), .EBITS(EB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_p (start_p),
        .x       (x),
        .e       (e),
        .e_bits  (e_bits),
        .m       (m),
        .m_size  (m_size),
        .r2_red  (r2_red),
        .busy    (busy),
        .result  (result),
        .done_p  (done_p),
        .mm      (mm_if)
    );

    // a*b*R^-1 mod m with R = 2^ms, by brute-force inverse.
    function automatic int mont(input int a, input int b, input int mod, input int ms);
        int r;
        int rinv;
        if (mod <= 1) return 0;
        r    = (1 << ms) % mod;
        rinv = 0;
        for (int k = 1; k < mod; k++)
            if ((r * k) % mod == 1) rinv = k;
        return (((a * b) % mod) * rinv) % mod;
    endfunction

    logic          mdl_done = 1'b0;
    logic [NB-1:0] mdl_y = '0;
    logic [NB-1:0] pend_y = '0;
    logic          inj_done = 1'b0;
    logic [NB-1:0] inj_y = '0;
    int            cnt = 0;
    int            n_ops = 0;

    assign mm_if.done_p = mdl_done | inj_done;
    assign mm_if.y      = inj_done ? inj_y : mdl_y;

    always @(posedge clk) begin
        mdl_done <= 1'b0;
        if (!rst_n) begin
            cnt <= 0;
        end else if (mm_if.enable_p) begin
            cnt    <= LAT;
            pend_y <= NB'(mont(int'(mm_if.a), int'(mm_if.b), int'(mm_if.m), int'(mm_if.m_size)));
            n_ops  <= n_ops + 1;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                mdl_done <= 1'b1;
                mdl_y    <= pend_y;
            end
        end
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Called on a negedge; leaves the bench one negedge after done_p.
    task automatic run_job(input int vx, input int ve, input int veb, input int vm, input int vms,
                           input int vr2, input int intr_at, input bit poke_done,
                           output int res, output int ops, output int busy_ok,
                           output int pulse_ok, output int mm_ok, output int tmo);
        int ops0;
        bit intruded;
        bit seen;
        ops0 = n_ops; intruded = 1'b0; seen = 1'b0;
        busy_ok = 1; pulse_ok = 1; mm_ok = 1; tmo = 1; res = -1; ops = 0;
        x = NB'(vx); e = EB'(ve); e_bits = EW'(veb);
        m = NB'(vm); m_size = MW'(vms); r2_red = NB'(vr2);
        start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (done_p) begin
                seen = 1'b1;
                break;
            end
            if (!busy) busy_ok = 0;
            if (intr_at > 0 && !intruded && (n_ops - ops0) == intr_at) begin
                x = NB'(5);
                start_p = 1'b1;
                intruded = 1'b1;
            end else begin
                start_p = 1'b0;
            end
            @(negedge clk);
        end
        start_p = 1'b0;
        if (seen) begin
            tmo = 0;
            res = int'(result);
            ops = n_ops - ops0;
            if (busy) busy_ok = 0;
            if (mm_if.m != NB'(vm) || mm_if.m_size != MW'(vms)) mm_ok = 0;
            if (poke_done) start_p = 1'b1;
            @(negedge clk);
            start_p = 1'b0;
            if (done_p) pulse_ok = 0;
            if (busy) busy_ok = 0;
        end
    endtask

    typedef struct {
        int x, e, eb, m, ms, r2, res, ops_plain, ops_ct;
    } vec_t;

    vec_t vecs[10];

    task automatic check_job(input string tag, input int res, input int ops, input int busy_ok,
                             input int pulse_ok, input int mm_ok, input int tmo,
                             input int exp_res, input int exp_ops);
        check({tag, "_timeout"}, tmo, 0);
        check({tag, "_result"}, res, exp_res);
        check({tag, "_ops"}, ops, exp_ops);
        check({tag, "_busy"}, busy_ok, 1);
        check({tag, "_done_pulse"}, pulse_ok, 1);
        check({tag, "_mm_m"}, mm_ok, 1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done_p"}, int'(done_p), 0);
        check({tag, "_result"}, int'(result), 0);
        check({tag, "_mm_en"}, int'(mm_if.enable_p), 0);
        check({tag, "_mm_a"}, int'(mm_if.a), 0);
        check({tag, "_mm_b"}, int'(mm_if.b), 0);
        check({tag, "_mm_m"}, int'(mm_if.m), 0);
        check({tag, "_mm_msize"}, int'(mm_if.m_size), 0);
    endtask

    initial begin
        int res, ops, bok, pok, mok, tmo, ops0;
        bit reached;

        //            x    e    eb  m   ms r2 res plain ct
        vecs[0] = '{  2,   5,   3, 13, 4, 9,  6,  8,  9};
        vecs[1] = '{  2,   0,   0, 13, 4, 9,  1,  3,  3};
        vecs[2] = '{ 12, 255,   8, 13, 4, 9, 12, 19, 19};
        vecs[3] = '{ 12, 128,   8, 13, 4, 9,  1, 12, 19};
        vecs[4] = '{  3,   4,   3, 13, 4, 9,  3,  7,  9};
        vecs[5] = '{  2, 129,  15, 13, 4, 9,  5, 13, 19};
        vecs[6] = '{  2, 255,   2, 13, 4, 9,  8,  7,  7};
        vecs[7] = '{  7,   3,   2, 11, 4, 3,  2,  7,  7};
        vecs[8] = '{  5,   1,   1, 13, 4, 9,  5,  5,  5};
        vecs[9] = '{  5,   0,   1, 13, 4, 9,  1,  4,  5};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_job(vecs[i].x, vecs[i].e, vecs[i].eb, vecs[i].m, vecs[i].ms, vecs[i].r2,
                    0, 1'b0, res, ops, bok, pok, mok, tmo);
            check_job($sformatf("v%0d", i), res, ops, bok, pok, mok, tmo, vecs[i].res,
                      CT_MODE ? vecs[i].ops_ct : vecs[i].ops_plain);
        end

        // Second start while busy in SQR with a different base.
        run_job(2, 5, 3, 13, 4, 9, 3, 1'b0, res, ops, bok, pok, mok, tmo);
        check_job("busy_start", res, ops, bok, pok, mok, tmo, 6, CT_MODE ? 9 : 8);

        // Start on the DONE cycle is ignored, start on the first IDLE cycle is taken.
        run_job(12, 255, 8, 13, 4, 9, 0, 1'b1, res, ops, bok, pok, mok, tmo);
        check_job("done_start", res, ops, bok, pok, mok, tmo, 12, 19);
        run_job(2, 5, 3, 13, 4, 9, 0, 1'b0, res, ops, bok, pok, mok, tmo);
        check_job("idle_start", res, ops, bok, pok, mok, tmo, 6, CT_MODE ? 9 : 8);

        // Reset while in MUL, then a stale multiplier done while idle.
        ops0 = n_ops;
        x = NB'(2); e = EB'(5); e_bits = EW'(3); m = NB'(13); m_size = MW'(4); r2_red = NB'(9);
        start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (n_ops - ops0 >= 4) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reach_mul", int'(reached), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle("abort");
        rst_n = 1'b1;
        inj_y = NB'(8'h55);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        check("stale_result", int'(result), 0);
        check("stale_busy", int'(busy), 0);
        check("stale_mm_en", int'(mm_if.enable_p), 0);
        check("stale_done_p", int'(done_p), 0);
        run_job(3, 4, 3, 13, 4, 9, 0, 1'b0, res, ops, bok, pok, mok, tmo);
        check_job("post_reset", res, ops, bok, pok, mok, tmo, 3, CT_MODE ? 9 : 7);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
